adda_stream: RTL and testbench

Parametrised ADC-to-DAC streaming block for the ULX3S J2 converter pair. It generates divided, complementary converter clocks and captures ADC samples. Each sample passes through a selectable processing mode (offset/saturate, bitmask, ramp test pattern, DC hold) before driving the DAC port. Running min/max statistics and a sticky saturation flag go to the board-level LED and debug logic. It sits directly between the top-level J2 pins and the `i_clk` (25 MHz) domain.

---
 rtl/adda_pkg.sv | 11 +
 rtl/adda_clkgen.sv | 49 ++++
 rtl/adda_stream.sv | 109 ++++++++++
 tb/tb_adda_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adda_pkg.sv
// adda_pkg: shared mode type and mode encodings for the ADC-to-DAC streaming block.
package adda_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'd0;
    localparam mode_t MODE_MASK = 2'd1;
    localparam mode_t MODE_RAMP = 2'd2;
    localparam mode_t MODE_HOLD = 2'd3;

endpackage

// File: rtl/adda_clkgen.sv
// adda_clkgen: divided complementary converter clocks with registered edge ticks.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   div       - half-period length minus 1, latched only at half-period boundaries
//   ad_clk    - ADC clock (the phase register)
//   da_clk    - DAC clock, exact complement of ad_clk
//   tick_rise - high for the cycle after ad_clk rose
//   tick_fall - high for the cycle after ad_clk fell
module adda_clkgen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             ad_clk,
    output logic             da_clk,
    output logic             tick_rise,
    output logic             tick_fall
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_l;
    logic             wrap;

    assign wrap = (cnt == div_l);

    // div is only sampled on a wrap, so a new setting never shortens the
    // half-period in progress and no runt pulses reach the converters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            div_l     <= '0;
            ad_clk    <= 1'b0;
            da_clk    <= 1'b1;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : cnt + 1'b1;
            tick_rise <= wrap & ~ad_clk;
            tick_fall <= wrap & ad_clk;
            if (wrap) begin
                div_l  <= div;
                ad_clk <= ~ad_clk;
                da_clk <= ad_clk;
            end
        end
    end

endmodule

// File: rtl/adda_stream.sv
// adda_stream: ADC capture, per-sample processing and DAC drive with running statistics.
//   i_clk, i_rst_n        - system clock, asynchronous active-low reset
//   i_div                 - converter half-period in i_clk cycles minus 1
//   i_mode                - PASS / MASK / RAMP / HOLD
//   i_mask                - AND mask (MASK) or constant output (HOLD)
//   i_offset              - signed offset added in PASS mode
//   i_stat_clr            - synchronous clear of min/max/sat
//   i_ad_data             - ADC parallel data
//   o_ad_clk, o_da_clk    - complementary converter clocks
//   o_da_data             - DAC parallel data
//   o_sample_stb          - one-cycle pulse when o_da_data updates
//   o_min, o_max, o_sat   - raw-sample statistics and sticky saturation flag
module adda_stream
    import adda_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIV_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  mode_t            i_mode,
    input  logic [W-1:0]     i_mask,
    input  logic [W-1:0]     i_offset,
    input  logic             i_stat_clr,
    input  logic [W-1:0]     i_ad_data,
    output logic             o_ad_clk,
    output logic             o_da_clk,
    output logic [W-1:0]     o_da_data,
    output logic             o_sample_stb,
    output logic [W-1:0]     o_min,
    output logic [W-1:0]     o_max,
    output logic             o_sat
);

    logic         tick_rise;
    logic         tick_fall;
    logic [W-1:0] raw;
    logic [W-1:0] ramp;
    logic [W+1:0] sum;
    logic         clip;
    logic [W-1:0] pass_val;
    logic [W-1:0] next_data;

    adda_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .div      (i_div),
        .ad_clk   (o_ad_clk),
        .da_clk   (o_da_clk),
        .tick_rise(tick_rise),
        .tick_fall(tick_fall)
    );

    // Two guard bits: bit W+1 flags a negative result, bit W an overflow.
    assign sum      = {2'b00, raw} + {{2{i_offset[W-1]}}, i_offset};
    assign clip     = sum[W+1] | sum[W];
    assign pass_val = sum[W+1] ? '0 : sum[W] ? '1 : sum[W-1:0];

    always_comb begin
        next_data = (i_mode == MODE_PASS) ? pass_val :
                    (i_mode == MODE_MASK) ? (raw & i_mask) :
                    (i_mode == MODE_RAMP) ? ramp : i_mask;
    end

    // Capture while the DAC clock rises, update half a period later so the
    // DAC latches a value that has been stable for a full half-period.
    // The ramp is held at zero on every update outside RAMP mode, so entering
    // RAMP always starts the pattern from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raw          <= '0;
            ramp         <= '0;
            o_da_data    <= '0;
            o_sample_stb <= 1'b0;
        end else begin
            o_sample_stb <= tick_rise;
            if (tick_fall)
                raw <= i_ad_data;
            if (tick_rise) begin
                o_da_data <= next_data;
                ramp      <= (i_mode == MODE_RAMP) ? ramp + 1'b1 : '0;
            end
        end
    end

    // Clear has priority over a coincident sample or saturation event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_min <= '1;
            o_max <= '0;
            o_sat <= 1'b0;
        end else if (i_stat_clr) begin
            o_min <= '1;
            o_max <= '0;
            o_sat <= 1'b0;
        end else begin
            if (tick_fall) begin
                o_min <= (i_ad_data < o_min) ? i_ad_data : o_min;
                o_max <= (i_ad_data > o_max) ? i_ad_data : o_max;
            end
            if (tick_rise && i_mode == MODE_PASS && clip)
                o_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adda_stream.sv
// tb_adda_stream: directed table-driven and sequence checks of adda_stream.
module tb_adda_stream;

    localparam int W     = 8;
    localparam int DIV_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [1:0]       mode = 2'd0;
    logic [W-1:0]     mask = '0;
    logic [W-1:0]     offset = '0;
    logic             clr = 1'b0;
    logic [W-1:0]     ad = '0;
    logic             ad_clk, da_clk, stb, sat;
    logic [W-1:0]     da_data, min_v, max_v;

    int total = 0;
    int bad = 0;

    adda_stream #(.W(W), .DIV_W(DIV_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_div       (div),
        .i_mode      (mode),
        .i_mask      (mask),
        .i_offset    (offset),
        .i_stat_clr  (clr),
        .i_ad_data   (ad),
        .o_ad_clk    (ad_clk),
        .o_da_clk    (da_clk),
        .o_da_data   (da_data),
        .o_sample_stb(stb),
        .o_min       (min_v),
        .o_max       (max_v),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bounded wait for the next strobe; returns the number of cycles waited.
    task automatic wait_stb(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!stb && cyc < 64);
        chk("stb_seen", {31'b0, stb}, 1);
    endtask

    // Bounded count of cycles until o_ad_clk next changes.
    task automatic half_period(output int n);
        logic prev;
        prev = ad_clk;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ad_clk == prev && n < 40);
    endtask

    // The DAC clock must be the complement of the ADC clock at all times.
    always @(negedge clk) chk("clk_compl", {31'b0, da_clk ^ ad_clk}, 1);

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] mask;
        logic [7:0] offset;
        logic [7:0] ad;
        logic       clr;
        logic [7:0] exp_data;
        logic       exp_sat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cyc;
        int n;
        logic prev;

        tbl[0]  = '{2'd0, 8'h00, 8'h00, 8'h10, 1'b0, 8'h10, 1'b0};
        tbl[1]  = '{2'd0, 8'h00, 8'h00, 8'h20, 1'b0, 8'h20, 1'b0};
        tbl[2]  = '{2'd0, 8'h00, 8'h00, 8'h30, 1'b0, 8'h30, 1'b0};
        tbl[3]  = '{2'd0, 8'h00, 8'h20, 8'hF0, 1'b0, 8'hFF, 1'b1};
        tbl[4]  = '{2'd0, 8'h00, 8'hE0, 8'h10, 1'b0, 8'h00, 1'b1};
        tbl[5]  = '{2'd0, 8'h00, 8'h00, 8'h55, 1'b1, 8'h55, 1'b0};
        tbl[6]  = '{2'd1, 8'h0F, 8'h00, 8'hA5, 1'b0, 8'h05, 1'b0};
        tbl[7]  = '{2'd3, 8'h3C, 8'h00, 8'hA5, 1'b0, 8'h3C, 1'b0};
        tbl[8]  = '{2'd0, 8'h00, 8'h05, 8'h7F, 1'b0, 8'h84, 1'b0};
        tbl[9]  = '{2'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[10] = '{2'd0, 8'h00, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
        tbl[11] = '{2'd1, 8'hFF, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ad_clk", {31'b0, ad_clk}, 0);
        chk("rst_da_clk", {31'b0, da_clk}, 1);
        chk("rst_data", {24'b0, da_data}, 8'h00);
        chk("rst_stb", {31'b0, stb}, 0);
        chk("rst_min", {24'b0, min_v}, 8'hFF);
        chk("rst_max", {24'b0, max_v}, 8'h00);
        chk("rst_sat", {31'b0, sat}, 0);

        // div=0: first rise one cycle after release, then toggling every cycle
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_rise", {31'b0, ad_clk}, 1);
        for (int i = 0; i < 8; i++) begin
            prev = ad_clk;
            @(negedge clk);
            chk("toggle_div0", {31'b0, ad_clk ^ prev}, 1);
        end

        // Capture-to-update latency of one cycle at div=0
        wait_stb(cyc);
        ad = 8'h66;
        @(negedge clk);
        chk("lat_stb_low", {31'b0, stb}, 0);
        @(negedge clk);
        chk("lat_stb_high", {31'b0, stb}, 1);
        chk("lat_data", {24'b0, da_data}, 8'h66);

        // Table: apply just after a strobe, check at the following strobe
        for (int i = 0; i < 12; i++) begin
            mode   = tbl[i].mode;
            mask   = tbl[i].mask;
            offset = tbl[i].offset;
            ad     = tbl[i].ad;
            clr    = tbl[i].clr;
            if (tbl[i].clr) begin
                @(negedge clk);
                clr = 1'b0;
            end
            wait_stb(cyc);
            chk($sformatf("vec%0d_data", i), {24'b0, da_data}, {24'b0, tbl[i].exp_data});
            chk($sformatf("vec%0d_sat", i), {31'b0, sat}, {31'b0, tbl[i].exp_sat});
        end

        // Statistics at div=0 (strobe cycle coincides with a capture cycle)
        ad  = 8'h40;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_stb(cyc);
        wait_stb(cyc);
        chk("stat_min_40", {24'b0, min_v}, 8'h40);
        chk("stat_max_40", {24'b0, max_v}, 8'h40);
        ad = 8'h08;
        wait_stb(cyc);
        ad = 8'hC0;
        wait_stb(cyc);
        chk("stat_min", {24'b0, min_v}, 8'h08);
        chk("stat_max", {24'b0, max_v}, 8'hC0);
        ad  = 8'h01;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_min", {24'b0, min_v}, 8'hFF);
        chk("clr_max", {24'b0, max_v}, 8'h00);
        chk("clr_sat", {31'b0, sat}, 0);
        wait_stb(cyc);
        @(negedge clk);
        chk("post_clr_min", {24'b0, min_v}, 8'h01);
        chk("post_clr_max", {24'b0, max_v}, 8'h01);

        // RAMP at div=2: one value per 6 cycles, wrapping 255 -> 0
        div = 4'd2;
        repeat (3) wait_stb(cyc);
        mode = 2'd2;
        for (int k = 0; k <= 256; k++) begin
            wait_stb(cyc);
            chk($sformatf("ramp%0d", k), {24'b0, da_data}, k % 256);
            chk("ramp_spacing", cyc, 6);
        end
        mode = 2'd0;
        wait_stb(cyc);
        mode = 2'd2;
        wait_stb(cyc);
        chk("ramp_restart0", {24'b0, da_data}, 8'h00);
        wait_stb(cyc);
        chk("ramp_restart1", {24'b0, da_data}, 8'h01);

        // Divider change mid-half-period: current stays 2, later ones are 4
        mode = 2'd0;
        div  = 4'd1;
        repeat (3) wait_stb(cyc);
        half_period(n);
        div = 4'd3;
        half_period(n);
        chk("half_cur", n, 2);
        half_period(n);
        chk("half_new1", n, 4);
        half_period(n);
        chk("half_new2", n, 4);

        // Asynchronous reset mid-run, away from any clock edge
        ad = 8'h9A;
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ad_clk", {31'b0, ad_clk}, 0);
        chk("arst_da_clk", {31'b0, da_clk}, 1);
        chk("arst_data", {24'b0, da_data}, 8'h00);
        chk("arst_stb", {31'b0, stb}, 0);
        chk("arst_min", {24'b0, min_v}, 8'hFF);
        chk("arst_max", {24'b0, max_v}, 8'h00);
        chk("arst_sat", {31'b0, sat}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
